// File: rtl/cla_adder_4bit_pkg.sv
// -----------------------------------------------------------------------------
// cla_adder_4bit_pkg
// Shared constants and helpers for the registered carry-lookahead adder.
//   GROUP_W    : width of one lookahead group (always 4)
//   num_groups : number of lookahead groups for a given operand width
//   width_ok   : true when a width is a positive multiple of GROUP_W
// -----------------------------------------------------------------------------
package cla_adder_4bit_pkg;

   localparam int GROUP_W = 4;

   function automatic int num_groups(input int width);
      return width / GROUP_W;
   endfunction

   function automatic bit width_ok(input int width);
      return (width > 0) && ((width % GROUP_W) == 0);
   endfunction

endpackage

// File: rtl/cla_adder_4bit_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Purely combinational 4-bit carry-lookahead group.
//   a_i, b_i : 4-bit operand slices
//   c_i      : carry into the group
//   sum_o    : 4-bit sum slice
//   g_o      : group generate (carry-out of the group when c_i = 0)
//   p_o      : group propagate (carry-in passes straight through)
// Internal carries use flattened sum-of-products so no carry ripples
// through the group.
// -----------------------------------------------------------------------------
module cla_group4
   import cla_adder_4bit_pkg::*;
(
   input  logic [GROUP_W-1:0] a_i,
   input  logic [GROUP_W-1:0] b_i,
   input  logic               c_i,
   output logic [GROUP_W-1:0] sum_o,
   output logic               g_o,
   output logic               p_o
);

   logic [GROUP_W-1:0] g;
   logic [GROUP_W-1:0] p;
   logic [GROUP_W-1:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Each carry is expressed directly in terms of g, p and c_i.
   assign c[0] = c_i;
   assign c[1] = g[0]
               | (p[0] & c_i);
   assign c[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & c_i);
   assign c[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_i);

   assign sum_o = p ^ c;

   // Group generate excludes the carry-in term; group propagate is the AND of all p.
   assign g_o = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
   assign p_o = &p;

endmodule

// File: rtl/cla_adder_4bit.sv
// -----------------------------------------------------------------------------
// cla_adder_4bit
// Registered carry-lookahead adder: {cout, sum} = a + b + cin, one cycle
// latency, one operation per cycle.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears all outputs
//   in_valid  : operands valid this cycle
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry-in
//   out_valid : registered result valid
//   sum, cout : registered sum (mod 2^WIDTH) and carry-out
//   grp_g     : registered block generate (carry-out when cin = 0)
//   grp_p     : registered block propagate (AND of all bit propagates)
//
// Handshake: valid-only, no ready. An edge with in_valid=1 captures a result
// and sets out_valid for exactly the following cycle; an edge with
// in_valid=0 clears out_valid while sum/cout/grp_g/grp_p keep their values.
// -----------------------------------------------------------------------------
module cla_adder_4bit
   import cla_adder_4bit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             grp_g,
   output logic             grp_p
);

   localparam int NUM_GROUPS = num_groups(WIDTH);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("cla_adder_4bit: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   logic [WIDTH-1:0]      sum_w;
   logic [NUM_GROUPS-1:0] grp_gen;
   logic [NUM_GROUPS-1:0] grp_prop;
   logic [NUM_GROUPS:0]   gc;   // carries between groups, gc[0] = cin
   logic [NUM_GROUPS:0]   bg;   // same chain with zero carry-in, gives block generate

   for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
      cla_group4 u_grp (
         .a_i   (a[k*GROUP_W +: GROUP_W]),
         .b_i   (b[k*GROUP_W +: GROUP_W]),
         .c_i   (gc[k]),
         .sum_o (sum_w[k*GROUP_W +: GROUP_W]),
         .g_o   (grp_gen[k]),
         .p_o   (grp_prop[k])
      );
   end

   // Inter-group carries from group G/P only; group G/P never depend on gc,
   // so this chain has no combinational loop through the instances.
   always_comb begin
      gc    = '0;
      bg    = '0;
      gc[0] = cin;
      for (int k = 0; k < NUM_GROUPS; k++) begin
         gc[k+1] = grp_gen[k] | (grp_prop[k] & gc[k]);
         bg[k+1] = grp_gen[k] | (grp_prop[k] & bg[k]);
      end
   end

   // Output register stage
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             grp_g_q, grp_g_d;
   logic             grp_p_q, grp_p_d;
   logic             out_valid_q, out_valid_d;

   always_comb begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      grp_g_d     = grp_g_q;
      grp_p_d     = grp_p_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d   = sum_w;
         cout_d  = gc[NUM_GROUPS];
         grp_g_d = bg[NUM_GROUPS];
         grp_p_d = &grp_prop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         grp_g_q     <= 1'b0;
         grp_p_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         grp_g_q     <= grp_g_d;
         grp_p_q     <= grp_p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign grp_g     = grp_g_q;
   assign grp_p     = grp_p_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_adder_4bit.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_4bit
// Directed bench for the registered 4-bit carry-lookahead adder.
// Observed tuple layout: {out_valid, cout, grp_g, grp_p, sum[3:0]}.
// -----------------------------------------------------------------------------
module tb_cla_adder_4bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       out_valid;
   logic [3:0] sum;
   logic       cout;
   logic       grp_g;
   logic       grp_p;

   logic [7:0] obs;
   assign obs = {out_valid, cout, grp_g, grp_p, sum};

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] exp_q[$];

   cla_adder_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout),
      .grp_g     (grp_g),
      .grp_p     (grp_p)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: result of a captured valid operation.
   function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y,
                                        input logic c);
      logic [4:0] s;
      logic [4:0] s0;
      s  = {1'b0, x} + {1'b0, y} + {4'b0000, c};
      s0 = {1'b0, x} + {1'b0, y};
      return {1'b1, s[4], s0[4], ((x ^ y) == 4'hF), s[3:0]};
   endfunction

   task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y,
                        input logic c);
      @(negedge clk);
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 4'($urandom_range(0, 15));
      b        = 4'($urandom_range(0, 15));
      cin      = 1'($urandom_range(0, 1));
      #3;
      vec_cnt++;
      if (obs !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_before_edge: got %b expected %b", obs, 8'h00);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_over_edge: got %b expected %b", obs, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_set1();
      drive(1'b1, 4'b0011, 4'b0111, 1'b0);
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1000_1010) begin
         err_cnt++;
         $display("FAIL set1: got %b expected %b", obs, 8'b1000_1010);
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 4'b0111, 4'b1010, 1'b0);
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1110_0001) begin
         err_cnt++;
         $display("FAIL overflow: got %b expected %b", obs, 8'b1110_0001);
      end
   endtask

   task automatic test_carry_in();
      drive(1'b1, 4'b0011, 4'b0111, 1'b1);
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1000_1011) begin
         err_cnt++;
         $display("FAIL carry_in: got %b expected %b", obs, 8'b1000_1011);
      end
   endtask

   task automatic test_full_propagate();
      drive(1'b1, 4'b1111, 4'b0000, 1'b1);
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1101_0000) begin
         err_cnt++;
         $display("FAIL propagate_cin1: got %b expected %b", obs, 8'b1101_0000);
      end
      drive(1'b1, 4'b1111, 4'b0000, 1'b0);
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1001_1111) begin
         err_cnt++;
         $display("FAIL propagate_cin0: got %b expected %b", obs, 8'b1001_1111);
      end
   endtask

   // Last captured result is 1111 / cout 0 / grp_p 1; it must hold while idle.
   task automatic test_hold();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
         @(posedge clk); #1;
         vec_cnt++;
         if (obs !== 8'b0001_1111) begin
            err_cnt++;
            $display("FAIL hold_%0d: got %b expected %b", i, obs, 8'b0001_1111);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] v;
      logic [7:0] exp_v;
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         drive(1'b1, v[3:0], v[7:4], v[8]);
         exp_q.push_back(model(v[3:0], v[7:4], v[8]));
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         vec_cnt++;
         if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL sweep a=%h b=%h cin=%b: got %b expected %b",
                     v[3:0], v[7:4], v[8], obs, exp_v);
         end
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 4'd5, 4'd6, 1'b0);
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1000_1011) begin
         err_cnt++;
         $display("FAIL pre_reset: got %b expected %b", obs, 8'b1000_1011);
      end
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (obs !== 8'h00) begin
         err_cnt++;
         $display("FAIL mid_reset: got %b expected %b", obs, 8'h00);
      end
      // Release with a fresh operation pending; first result one edge later.
      drive(1'b1, 4'd9, 4'd9, 1'b1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== 8'b1110_0011) begin
         err_cnt++;
         $display("FAIL after_reset: got %b expected %b", obs, 8'b1110_0011);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      test_reset();
      test_set1();
      test_overflow();
      test_carry_in();
      test_full_propagate();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
